// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1 - N:1 data multiplexer with round-robin arbitration and a
// one-entry registered output stage using valid/ready handshakes.
//
// Parameters:
//   WIDTH  data bits per channel
//   N      number of input channels (>=2)
//   SELW   channel index width, derived from N
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_data     packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready (one-hot or zero)
//   in_last     end-of-packet flags (only with MUX_ARB_LOCK_EN)
//   out_data    held beat
//   out_sel     channel index that supplied out_data
//   out_valid   output register holds a beat
//   out_ready   consumer takes the beat this cycle
//
// Build option: define MUX_ARB_LOCK_EN to keep the grant on one channel
// until it transfers a beat with in_last set.
module mux_arb_nto1 #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 4,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_next;
  logic [SELW-1:0]  grant_idx;
  logic             grant_hit;
  logic             open;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

`ifdef MUX_ARB_LOCK_EN
  typedef enum logic {ARB_FREE, ARB_LOCKED} lock_state_t;
  lock_state_t     lock_state, lock_state_next;
  logic [SELW-1:0] lock_sel;
`endif

  always_comb begin
    int unsigned idx;
    idx       = 0;
    open      = !out_valid || out_ready;
    grant_hit = 1'b0;
    grant_idx = '0;
    // Rotating scan starting at ptr; the index is reduced by hand so that
    // non-power-of-2 N wraps correctly.
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_hit && in_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = SELW'(idx);
      end
    end
`ifdef MUX_ARB_LOCK_EN
    if (lock_state == ARB_LOCKED) begin
      grant_hit = in_valid[lock_sel];
      grant_idx = lock_sel;
    end
`endif
    // Gate with rst so ready stays low while reset is held.
    xfer     = open && grant_hit && !rst;
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;

    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end

    ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
`ifdef MUX_ARB_LOCK_EN
      // Pointer only moves when a packet ends.
      if (in_last[grant_idx]) ptr <= ptr_next;
`else
      ptr <= ptr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_comb begin
    lock_state_next = lock_state;
    if (xfer) lock_state_next = in_last[grant_idx] ? ARB_FREE : ARB_LOCKED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= ARB_FREE;
      lock_sel   <= '0;
    end else begin
      lock_state <= lock_state_next;
      if (xfer) lock_sel <= grant_idx;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Testbench for mux_arb_nto1: a 4-channel and a 3-channel instance are
// driven with directed and random traffic and compared every cycle against
// a behavioural model of the arbitration rules.
module tb_mux_arb_nto1;

`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         sel;
    int         ptr;
    bit         locked;
    int         lock_ch;
  } mstate_t;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] data_a;
  logic [3:0]  v_a, rdy_a, last_a;
  logic        or_a, ov_a;
  logic [7:0]  od_a;
  logic [1:0]  os_a;

  logic [23:0] data_b;
  logic [2:0]  v_b, rdy_b, last_b;
  logic        or_b, ov_b;
  logic [7:0]  od_b;
  logic [1:0]  os_b;

  int n_checks = 0;
  int n_errors = 0;
  mstate_t ma, mb, na, nb;

  always #5 clk = ~clk;

  mux_arb_nto1 #(.WIDTH(8), .N(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(data_a), .in_valid(v_a),
`ifdef MUX_ARB_LOCK_EN
    .in_last(last_a),
`endif
    .in_ready(rdy_a), .out_data(od_a), .out_sel(os_a),
    .out_valid(ov_a), .out_ready(or_a)
  );

  mux_arb_nto1 #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(data_b), .in_valid(v_b),
`ifdef MUX_ARB_LOCK_EN
    .in_last(last_b),
`endif
    .in_ready(rdy_b), .out_data(od_b), .out_sel(os_b),
    .out_valid(ov_b), .out_ready(or_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t s;
    s.v = 1'b0; s.d = 8'h00; s.sel = 0; s.ptr = 0; s.locked = 1'b0; s.lock_ch = 0;
    return s;
  endfunction

  // Channel granted this cycle, or -1.
  function automatic int pick(input mstate_t s, input int n, input logic [3:0] v, input logic ordy);
    if (s.v && !ordy) return -1;
    if (s.locked) return v[s.lock_ch] ? s.lock_ch : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(s.ptr + k) % n]) return (s.ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int n, input logic [3:0] v,
                                   input logic [31:0] d, input logic [3:0] last, input logic ordy);
    mstate_t r;
    int g;
    r = s;
    g = pick(s, n, v, ordy);
    if (g >= 0) begin
      r.v = 1'b1;
      r.d = d[g*8 +: 8];
      r.sel = g;
      if (LOCK && !last[g]) begin
        r.locked = 1'b1;
        r.lock_ch = g;
      end else begin
        r.locked = 1'b0;
        r.ptr = (g + 1) % n;
      end
    end else if (ordy) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] onehot(input int g);
    return (g >= 0) ? (32'd1 << g) : 32'd0;
  endfunction

  // Entered and left at posedge+1; inputs are set by the caller beforehand.
  task automatic step_cycle();
    int ga, gb;
    #3;
    ga = pick(ma, 4, v_a, or_a);
    gb = pick(mb, 3, {1'b0, v_b}, or_b);
    check("rdy_a", 32'(rdy_a), rst ? 32'd0 : onehot(ga));
    check("rdy_b", 32'(rdy_b), rst ? 32'd0 : onehot(gb));
    if (rst) begin
      na = reset_state();
      nb = reset_state();
    end else begin
      na = step(ma, 4, v_a, data_a, last_a, or_a);
      nb = step(mb, 3, {1'b0, v_b}, {8'h00, data_b}, {1'b1, last_b}, or_b);
    end
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    check("ov_a", 32'(ov_a), 32'(ma.v));
    check("od_a", 32'(od_a), 32'(ma.d));
    check("os_a", 32'(os_a), 32'(ma.sel));
    check("ov_b", 32'(ov_b), 32'(mb.v));
    check("od_b", 32'(od_b), 32'(mb.d));
    check("os_b", 32'(os_b), 32'(mb.sel));
  endtask

  initial begin
    rst = 1'b1;
    data_a = '0; v_a = '0; last_a = '1; or_a = 1'b0;
    data_b = '0; v_b = '0; last_b = '1; or_b = 1'b0;
    ma = reset_state();
    mb = reset_state();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ov_a", 32'(ov_a), 32'd0);
    check("reset_rdy_a", 32'(rdy_a), 32'd0);
    rst = 1'b0;

    // Round robin, all channels valid
    data_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    v_a = 4'hF; or_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step_cycle();
      check("rr_data", 32'(od_a), 32'(8'hA0 + k % 4));
      check("rr_valid", 32'(ov_a), 32'd1);
    end

    // Asynchronous reset with a beat held
    #2 rst = 1'b1;
    #1;
    check("arst_ov", 32'(ov_a), 32'd0);
    check("arst_od", 32'(od_a), 32'd0);
    check("arst_os", 32'(os_a), 32'd0);
    check("arst_rdy", 32'(rdy_a), 32'd0);
    ma = reset_state();
    mb = reset_state();
    @(posedge clk);
    #1;
    step_cycle();
    rst = 1'b0;
    step_cycle();
    check("first_grant", 32'(os_a), 32'd0);

    // Drain: one beat, then no inputs
    v_a = 4'b0000;
    step_cycle();
    data_a = {8'h00, 8'h00, 8'h77, 8'h00};
    v_a = 4'b0010;
    step_cycle();
    v_a = 4'b0000;
    step_cycle();
    check("drain_ov", 32'(ov_a), 32'd0);
    check("drain_od", 32'(od_a), 32'h77);

    // Backpressure on ch2
    data_a = {8'h00, 8'h5C, 8'h00, 8'h00};
    v_a = 4'b0100; or_a = 1'b0;
    for (int k = 0; k < 3; k++) step_cycle();
    check("bp_od", 32'(od_a), 32'h5C);
    check("bp_os", 32'(os_a), 32'd2);
    data_a = {8'h00, 8'h5D, 8'h00, 8'h00};
    or_a = 1'b1;
    step_cycle();
    check("bp_next", 32'(od_a), 32'h5D);
    v_a = 4'b0000;
    step_cycle();

    // Sparse grants and wrap on the 3-channel instance
    or_b = 1'b1;
    data_b = {8'hC2, 8'hC1, 8'hC0};
    v_b = 3'b100;
    step_cycle();
    check("wrap_sel2", 32'(os_b), 32'd2);
    v_b = 3'b001;
    step_cycle();
    check("wrap_sel0", 32'(os_b), 32'd0);
    v_b = 3'b000;
    step_cycle();
    step_cycle();
    v_b = 3'b111;
    step_cycle();
    check("wrap_next", 32'(os_b), 32'd1);
    v_b = 3'b000;
    step_cycle();

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: ch1 sends three beats while ch0 and ch3 compete
    rst = 1'b1;
    #1;
    ma = reset_state();
    mb = reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    or_a = 1'b1;
    data_a = {8'h33, 8'h22, 8'h11, 8'h00};
    v_a = 4'b0010; last_a = 4'b0000;
    step_cycle();
    check("lock_b0", 32'(os_a), 32'd1);
    v_a = 4'b1011;
    step_cycle();
    check("lock_b1", 32'(os_a), 32'd1);
    last_a = 4'b0010;
    step_cycle();
    check("lock_b2", 32'(os_a), 32'd1);
    last_a = 4'b1111;
    step_cycle();
    check("lock_rel", 32'(os_a), 32'd3);
`endif

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      data_a = $urandom;
      data_b = 24'($urandom);
      v_a    = 4'($urandom);
      v_b    = 3'($urandom);
      or_a   = ($urandom_range(0, 9) < 7);
      or_b   = ($urandom_range(0, 9) < 6);
      last_a = 4'($urandom) | 4'($urandom);
      last_b = 3'($urandom) | 3'($urandom);
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N:1 data multiplexer with round-robin arbitration and a registered, valid/ready handshaked output. It is the successor to the catalog's 2:1 select-line mux. Channel choice is made internally by a fair arbiter rather than by an external select, and each accepted beat is held in a one-entry output register until the consumer takes it. It sits wherever several producers share one downstream consumer, such as datapath merge points and request funnels.

## Interface
- WIDTH, 8, data bits per channel (>=1)
- N, 4, number of input channels (>=2)
- SELW, $clog2(N), width of the channel index (localparam, not overridable)

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; one-hot or zero
- out_data  output  WIDTH  registered data of the held beat
- out_sel  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a beat
- out_ready  input  1  consumer accepts the beat this cycle
- in_last  input  N  end-of-packet flag per channel; present only with MUX_ARB_LOCK_EN

## Operation
Definitions:
- State: out_data, out_sel, out_valid, round-robin pointer ptr (SELW bits), and lock state when enabled.
- open = !out_valid || out_ready (the output register can take a new beat this cycle).

Grant:
- When open, grant the first channel i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- in_ready[g]=1 for the granted channel g only. All other in_ready bits are 0.
- If not open, or no in_valid bit is set, in_ready is all zero.

Transfer:
- A channel transfers on in_valid[g] && in_ready[g].
- On a transfer: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N. The wrap from N-1 goes to 0, and must also hold for non-power-of-2 N.
- Output handshake without a new transfer: out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous output handshake and new transfer: the register is replaced with no bubble, giving 1 beat/cycle sustained.
- No output handshake: out_valid, out_data and out_sel hold.
- No transfer: ptr holds.
- A producer may drop in_valid without a transfer. The arbiter re-evaluates every cycle and has no memory of un-granted requests.

Reset:
- While rst is high: out_valid=0, out_data=0, out_sel=0, ptr=0, lock cleared, in_ready=0.
- Assertion mid-operation discards the held beat immediately, without waiting for a clock edge.

## Timing
- Input transfer to out_valid: 1 cycle.
- Combinational paths: in_valid -> in_ready and out_ready -> in_ready. No combinational path from any input to out_data, out_valid or out_sel.
- Fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive beats.
- First cycle after rst deassertion: arbitration is allowed, with priority starting at channel 0.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - The in_last port exists.
  - A transfer with in_last[g]=0 locks the grant to channel g. While locked, only g can be granted (in_ready[g] follows open && in_valid[g]), and ptr does not advance.
  - A transfer with in_last[g]=1 releases the lock and sets ptr <= (g+1) mod N.
  - rst clears the lock.
- MUX_ARB_LOCK_EN undefined:
  - There is no in_last port.
  - Arbitration runs independently on every beat, as described under Operation.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out_valid, out_data and out_sel go to 0 immediately; in_ready=0; first grant after release goes to ch0 when all channels are valid.
- Round robin: N=4, all in_valid=1, out_ready=1, in_data[i]=8'hA0+i -> out_data sequence A0, A1, A2, A3, A0..., out_valid high every cycle from cycle 2.
- Backpressure: ch2 only valid with data 8'h5C, out_ready=0 for 3 cycles -> out_data=5C and out_sel=2 held; in_ready=0 after the first transfer; the next beat is accepted in the same cycle out_ready rises.
- Sparse and wrap: N=3, only ch2 then only ch0 valid -> grants 2, then 0; ptr wraps 2 -> 0; with in_valid=0, ptr unchanged and in_ready=0.
- Lock (MUX_ARB_LOCK_EN): ch1 sends 3 beats with in_last=0,0,1 while ch0 and ch3 are valid -> out_sel=1,1,1, then ch3 is granted next.
- Drain: single beat accepted then out_ready=1 with no inputs -> out_valid drops after one cycle; out_data retains its value.
